// File: rtl/spi_rd_word_packer.sv
// Packs data-phase bytes of a flash READ little-endian into 32-bit words and
// queues them in a small word FIFO that feeds a valid/ready stream.
module spi_rd_word_packer #(
    parameter int BYTE_MAX   = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        rd_start,
    input  logic        data_phase,
    input  logic        rec_done,
    input  logic [7:0]  data_rec,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [31:0] word_data,
    output logic [3:0]  word_keep,
    output logic        word_last,
    output logic        xfer_done,
    output logic        ovf
);

    // state     | meaning
    // S_IDLE    | byte_cnt==0 after reset or rd_start, nothing captured yet
    // S_COLLECT | at least one byte captured, fewer than BYTE_MAX
    // S_DONE    | BYTE_MAX bytes captured; further bytes ignored

    localparam int              AW          = $clog2(FIFO_DEPTH);
    localparam logic [7:0]      LP_BYTE_MAX = 8'(BYTE_MAX);
    localparam logic [7:0]      LP_LAST     = 8'(BYTE_MAX - 1);
    localparam logic [AW:0]     LP_DEPTH    = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;

    logic [7:0]     r_byte_cnt;
    logic [31:0]    r_pack;
    logic           r_ovf;

    logic [31:0]    r_mem_data [FIFO_DEPTH];
    logic [3:0]     r_mem_keep [FIFO_DEPTH];
    logic           r_mem_last [FIFO_DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;

    logic           w_accept;
    logic [1:0]     w_lane;
    logic           w_is_last;
    logic           w_push_req;
    logic           w_pop;
    logic           w_full;
    logic           w_push;
    logic           w_drop;
    logic           w_valid;
    logic [31:0]    w_pack_next;
    logic [3:0]     w_keep_next;

    assign w_accept   = rec_done & data_phase & ~rd_start & (r_byte_cnt < LP_BYTE_MAX);
    assign w_lane     = r_byte_cnt[1:0];
    assign w_is_last  = (r_byte_cnt == LP_LAST);
    assign w_push_req = w_accept & ((w_lane == 2'd3) | w_is_last);
    assign w_valid    = (r_count != '0);
    assign w_pop      = w_valid & word_ready;
    assign w_full     = (r_count == LP_DEPTH);
    // A full FIFO still takes the word when the head leaves on the same edge.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;

    always_comb begin
        w_pack_next = r_pack;
        w_pack_next[{w_lane, 3'b000} +: 8] = data_rec;
    end

    always_comb begin
        w_keep_next = 4'b0001;
        case (w_lane)
            2'd0: w_keep_next = 4'b0001;
            2'd1: w_keep_next = 4'b0011;
            2'd2: w_keep_next = 4'b0111;
            2'd3: w_keep_next = 4'b1111;
            default: w_keep_next = 4'b0001;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (rd_start) begin
            w_state_next = S_IDLE;
        end else if (w_accept) begin
            w_state_next = w_is_last ? S_DONE : S_COLLECT;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_byte_cnt <= 8'd0;
            r_pack     <= 32'd0;
            r_ovf      <= 1'b0;
        end else begin
            if (rd_start) begin
                r_byte_cnt <= 8'd0;
                r_pack     <= 32'd0;
            end else if (w_accept) begin
                r_byte_cnt <= r_byte_cnt + 8'd1;
                r_pack     <= w_push_req ? 32'd0 : w_pack_next;
            end

            if (rd_start) begin
                r_ovf <= 1'b0;
            end else if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_pack_next;
            r_mem_keep[r_wr_ptr] <= w_keep_next;
            r_mem_last[r_wr_ptr] <= w_is_last;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head fields are gated so an empty FIFO shows zeros rather than stale entries.
    assign word_valid = w_valid;
    assign word_data  = w_valid ? r_mem_data[r_rd_ptr] : 32'd0;
    assign word_keep  = w_valid ? r_mem_keep[r_rd_ptr] : 4'd0;
    assign word_last  = w_valid ? r_mem_last[r_rd_ptr] : 1'b0;
    assign xfer_done  = (r_state == S_DONE);
    assign ovf        = r_ovf;

endmodule
